bin2bcd_seq: RTL
================

// Module: bin2bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-add-3 / double dabble) for the DDS front panel.
//   Accepts one binary word per start pulse and iterates the combinational shift_adjust stage
//   once per clock. Produces packed BCD digits for the display/scan logic downstream.
//   Trades WIDTH_BIN cycles of latency for a single adjust stage instead of a WIDTH_BIN-deep chain.
// PARAMETERS
//   WIDTH_BIN  18  binary input width; must be >= 2
//   WIDTH_BCD  24  BCD output width; multiple of 4, WIDTH_BCD/4 digits, LS digit in [3:0]
// PORTS
//   clk      in   1                      system clock, all logic on rising edge
//   rst      in   1                      synchronous, active-high reset
//   start    in   1                      request; sampled only while ready=1
//   bin_in   in   WIDTH_BIN              binary operand, captured on the accepted start edge
//   ready    out  1                      converter idle, start will be accepted
//   busy     out  1                      conversion in progress (= ~ready)
//   done     out  1                      one-cycle pulse: bcd_out/ovf are new this cycle
//   bcd_out  out  WIDTH_BCD              result, held until the next done
//   ovf      out  1                      result truncated (value >= 10^(WIDTH_BCD/4)), held with bcd_out
// BEHAVIOUR
//   Reset: state=IDLE, ready=1, busy=0, done=0, bcd_out=0, ovf=0, shift reg=0, count=0.
//   Reset dominates every other event; asserting rst mid-conversion aborts it, no done issued.
//   State register sr[WIDTH_BIN+WIDTH_BCD-1:0]: BCD field on top, binary field at bottom.
//   IDLE: start=1 at edge k -> sr <= {0, bin_in}, count <= 0, ovf_acc <= 0, state <= SHIFT.
//     start=0 -> stay; done=0.
//   SHIFT: one shift per edge, edges k+1 .. k+WIDTH_BIN.
//     count < WIDTH_BIN-1 : sr <= shift_adjust(sr)  (shift left 1, then +3 on each BCD nibble >= 5).
//     count = WIDTH_BIN-1 : sr <= sr << 1 (plain shift, no adjust); bcd_out <= BCD field of that
//       shifted value; ovf <= ovf_acc | sr[MSB]; done <= 1; state <= IDLE.
//     Every shift: ovf_acc <= ovf_acc | sr[MSB] (bit leaving the BCD field).
//     count increments by 1 per shift; no wrap (cleared on load).
//   Latency: done high in cycle following edge k+WIDTH_BIN, i.e. WIDTH_BIN cycles after accept.
//   ready=1 in the done cycle: a start there is accepted (back-to-back, throughput 1/(WIDTH_BIN+1)).
//   start while busy: ignored, no queueing; bin_in changes while busy: no effect.
//   done is a single-cycle pulse, deasserted on the next edge regardless of start.
//   bcd_out/ovf change only on the done edge or reset; stable during the next conversion.
//   Width rules: count is $clog2(WIDTH_BIN) bits (min 1); no arithmetic outside shift_adjust.
// STRUCTURE
//   Shared package/header bin2bcd_defs: state encodings (ST_IDLE, ST_SHIFT), CNT_W function.
//   Sub-module: one instance of shift_adjust #(WIDTH_BIN, WIDTH_BCD) on sr (existing block).
//   Single FSM + counter + sr register in this file; no other hierarchy.
// TESTING (defaults unless noted)
//   1 bin_in=0, start pulse -> done after 18 cycles, bcd_out=24'h000000, ovf=0.
//   2 bin_in=12345 -> bcd_out=24'h012345; bin_in=18'h3FFFF -> bcd_out=24'h262143, ovf=0.
//   3 start asserted in the done cycle with bin_in=999 -> accepted, next done 18 cycles later,
//     bcd_out=24'h000999; previous result held in between.
//   4 start pulses during busy with other bin_in -> ignored, exactly one done, result unchanged.
//   5 rst at cycle 5 of a conversion -> no done, bcd_out=0, ready=1 next cycle; new start works.
//   6 WIDTH_BIN=8, WIDTH_BCD=4: bin_in=9 -> 4'h9, ovf=0; bin_in=10 -> ovf=1; bin_in=255 -> ovf=1.
//   Scoreboard: compare every done against a reference integer-to-BCD model over 10k random inputs.

Source files
------------

// File: rtl/bin2bcd_defs.sv
// Shared definitions for the sequential binary-to-BCD converter.
// State encodings and the iteration counter width helper.
package bin2bcd_defs;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   function automatic int cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/shift_adjust.sv
// One double-dabble step: shift the whole register left by one,
// then add 3 to every BCD nibble that reached 5 or more.
module shift_adjust #(
   parameter int WIDTH_BIN = 18,
   parameter int WIDTH_BCD = 24
) (
   input  logic [WIDTH_BIN+WIDTH_BCD-1:0] sr,
   output logic [WIDTH_BIN+WIDTH_BCD-1:0] sr_next
);

   localparam int SW = WIDTH_BIN + WIDTH_BCD;
   localparam int ND = WIDTH_BCD / 4;

   logic [SW-1:0] shifted;
   logic [3:0]    nib;

   always_comb begin
      shifted = {sr[SW-2:0], 1'b0};
      sr_next = shifted;
      nib     = '0;
      for (int i = 0; i < ND; i++) begin
         nib = shifted[WIDTH_BIN+4*i +: 4];
         if (nib >= 4'd5)
            sr_next[WIDTH_BIN+4*i +: 4] = nib + 4'd3;
      end
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift_adjust step per clock.
// The final step is a plain shift so the result needs no post-correction.
module bin2bcd_seq
   import bin2bcd_defs::*;
#(
   parameter int WIDTH_BIN = 18,
   parameter int WIDTH_BCD = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH_BIN-1:0] bin_in,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH_BCD-1:0] bcd_out,
   output logic                 ovf
);

   localparam int SW = WIDTH_BIN + WIDTH_BCD;
   localparam int CW = cnt_w(WIDTH_BIN);
   localparam logic [CW-1:0] LAST = CW'(WIDTH_BIN - 1);

   state_t               state, state_n;
   logic [SW-1:0]        sr, sr_n, adj, shifted;
   logic [CW-1:0]        count, count_n;
   logic                 ovf_acc, ovf_acc_n;
   logic [WIDTH_BCD-1:0] bcd_n;
   logic                 ovf_n, done_n;

   shift_adjust #(
      .WIDTH_BIN (WIDTH_BIN),
      .WIDTH_BCD (WIDTH_BCD)
   ) u_adj (
      .sr      (sr),
      .sr_next (adj)
   );

   assign shifted = {sr[SW-2:0], 1'b0};
   assign ready   = (state == ST_IDLE);
   assign busy    = ~ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         sr      <= '0;
         count   <= '0;
         ovf_acc <= 1'b0;
         bcd_out <= '0;
         ovf     <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         sr      <= sr_n;
         count   <= count_n;
         ovf_acc <= ovf_acc_n;
         bcd_out <= bcd_n;
         ovf     <= ovf_n;
         done    <= done_n;
      end
   end

   always_comb begin
      state_n   = state;
      sr_n      = sr;
      count_n   = count;
      ovf_acc_n = ovf_acc;
      bcd_n     = bcd_out;
      ovf_n     = ovf;
      done_n    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               sr_n      = {{WIDTH_BCD{1'b0}}, bin_in};
               count_n   = '0;
               ovf_acc_n = 1'b0;
               state_n   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // the MSB leaving the BCD field marks a truncated result
            ovf_acc_n = ovf_acc | sr[SW-1];
            if (count == LAST) begin
               sr_n    = shifted;
               bcd_n   = shifted[SW-1:WIDTH_BIN];
               ovf_n   = ovf_acc_n;
               done_n  = 1'b1;
               state_n = ST_IDLE;
            end else begin
               sr_n    = adj;
               count_n = count + 1'b1;
            end
         end
      endcase
   end

endmodule
